// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, FSM state encoding and rotate/permute helpers.
package des_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_FINISHED = 2'd2
   } state_t;

   // Table entries use the standard's 1-based numbering (bit 1 = MSB).
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // S[1..16] stored at indices 0..15.
   localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] cd;
      cd = '0;
      for (int i = 0; i < 56; i++) begin
         cd[55-i] = key[64-PC1_TAB[i]];
      end
      return cd;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int amt);
      return (amt == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int amt);
      return (amt == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit {C,D} state into a 48-bit subkey.
module des_pc2
   import des_pkg::*;
(
   input  logic [55:0] cd,
   output logic [47:0] k
);

   for (genvar i = 0; i < 48; i++) begin : g_bit
      assign k[47-i] = cd[56-PC2_TAB[i]];
   end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: delivers K1..K16 (or K16..K1) one per consumer handshake.
module des_key_schedule
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        encrypt,
   input  logic [63:0] key,
   input  logic        next,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   output logic [3:0]  round,
   output logic        done,
   output logic        error
);

   state_t      state;
   logic [27:0] c_reg;
   logic [27:0] d_reg;
   logic        enc_reg;

   logic [55:0] key_cd;
   logic [27:0] c_adv;
   logic [27:0] d_adv;
   int          amt;

   // Advancing from round r needs S[r+2] going forward, S[16-r] going backward.
   always_comb begin
      key_cd = pc1(key);
      amt    = 1;
      if (round != 4'd15) begin
         if (enc_reg) amt = SHIFT_TAB[int'(round) + 1];
         else         amt = SHIFT_TAB[15 - int'(round)];
      end
      c_adv = enc_reg ? rotl28(c_reg, amt) : rotr28(c_reg, amt);
      d_adv = enc_reg ? rotl28(d_reg, amt) : rotr28(d_reg, amt);
   end

   des_pc2 u_pc2 (
      .cd ({c_reg, d_reg}),
      .k  (subkey)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         c_reg        <= '0;
         d_reg        <= '0;
         enc_reg      <= 1'b0;
         round        <= '0;
         subkey_valid <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         if (load) begin
            // Decrypt starts unrotated: the 16 shifts total 28, so PC-1 itself is K16.
            c_reg        <= encrypt ? rotl28(key_cd[55:28], 1) : key_cd[55:28];
            d_reg        <= encrypt ? rotl28(key_cd[27:0], 1)  : key_cd[27:0];
            enc_reg      <= encrypt;
            round        <= '0;
            state        <= ST_ACTIVE;
            subkey_valid <= 1'b1;
         end else if (next) begin
            case (state)
               ST_ACTIVE: begin
                  if (round == 4'd15) begin
                     state        <= ST_FINISHED;
                     subkey_valid <= 1'b0;
                     round        <= '0;
                     done         <= 1'b1;
                  end else begin
                     c_reg <= c_adv;
                     d_reg <= d_adv;
                     round <= round + 4'd1;
                  end
               end
               default: error <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule using the classic 133457799BBCDFF1 key.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic        encrypt;
   logic [63:0] key;
   logic        next;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic [3:0]  round;
   logic        done;
   logic        error;

   int tests = 0;
   int fails = 0;
   logic [47:0] exp_q [$];

   localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;
   localparam logic [27:0] C0   = 28'hF0CCAAF;
   localparam logic [27:0] D0   = 28'h556678F;
   localparam logic [27:0] C1   = 28'hE19955F;
   localparam logic [27:0] D1   = 28'hAACCF1E;
   localparam logic [47:0] KTAB [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   des_key_schedule dut (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .encrypt      (encrypt),
      .key          (key),
      .next         (next),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .round        (round),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; next = 1'b0; encrypt = 1'b0; key = '0;
      #3;
      tests++; if (subkey_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", subkey_valid); end
      tests++; if (round !== 4'd0) begin fails++; $display("FAIL reset_round got %0d want 0", round); end
      tests++; if (done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL reset_pulses got done=%b error=%b want 0/0", done, error); end
      tests++; if (dut.c_reg !== 28'd0 || dut.d_reg !== 28'd0) begin fails++; $display("FAIL reset_cd got %h/%h want 0/0", dut.c_reg, dut.d_reg); end
      step(); step();
      rst = 1'b0;
      step(); step();
      tests++; if (subkey_valid !== 1'b0 || round !== 4'd0) begin fails++; $display("FAIL idle_after_reset got valid=%b round=%0d want 0/0", subkey_valid, round); end
   endtask

   task automatic test_encrypt();
      logic [47:0] e;
      key = KEY0; encrypt = 1'b1; load = 1'b1;
      for (int i = 0; i < 16; i++) exp_q.push_back(KTAB[i]);
      step();
      load = 1'b0; next = 1'b1;
      for (int i = 0; i < 16; i++) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
         tests++; if (subkey !== e) begin fails++; $display("FAIL enc_subkey r%0d got %h want %h", i, subkey, e); end
         tests++; if (round !== 4'(i) || subkey_valid !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL enc_ctrl r%0d got round=%0d valid=%b done=%b want %0d/1/0", i, round, subkey_valid, done, i);
         end
         step();
      end
      next = 1'b0;
      tests++; if (done !== 1'b1 || subkey_valid !== 1'b0) begin fails++; $display("FAIL enc_done got done=%b valid=%b want 1/0", done, subkey_valid); end
      tests++; if (dut.c_reg !== C0 || dut.d_reg !== D0) begin fails++; $display("FAIL enc_final_cd got %h/%h want %h/%h", dut.c_reg, dut.d_reg, C0, D0); end
      tests++; if (round !== 4'd0) begin fails++; $display("FAIL finished_round got %0d want 0", round); end
      step();
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle got %b want 0", done); end
      next = 1'b1;
      step();
      next = 1'b0;
      tests++; if (error !== 1'b1 || subkey_valid !== 1'b0) begin fails++; $display("FAIL finished_error got error=%b valid=%b want 1/0", error, subkey_valid); end
      step();
      tests++; if (error !== 1'b0) begin fails++; $display("FAIL error_one_cycle got %b want 0", error); end
   endtask

   task automatic test_decrypt();
      logic [47:0] e;
      key = KEY0; encrypt = 1'b0; load = 1'b1;
      for (int i = 0; i < 16; i++) exp_q.push_back(KTAB[15-i]);
      step();
      load = 1'b0; next = 1'b1;
      for (int i = 0; i < 16; i++) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
         tests++; if (subkey !== e || round !== 4'(i)) begin
            fails++; $display("FAIL dec_subkey r%0d got %h round=%0d want %h round=%0d", i, subkey, round, e, i);
         end
         step();
      end
      next = 1'b0;
      tests++; if (done !== 1'b1 || subkey_valid !== 1'b0) begin fails++; $display("FAIL dec_done got done=%b valid=%b want 1/0", done, subkey_valid); end
      tests++; if (dut.c_reg !== C1 || dut.d_reg !== D1) begin fails++; $display("FAIL dec_final_cd got %h/%h want %h/%h", dut.c_reg, dut.d_reg, C1, D1); end
      step();
   endtask

   task automatic test_reverse_random();
      logic [47:0] seen [16];
      logic [47:0] e;
      for (int n = 0; n < 3; n++) begin
         key = {$urandom(), $urandom()}; encrypt = 1'b1; load = 1'b1;
         step();
         load = 1'b0; next = 1'b1;
         for (int i = 0; i < 16; i++) begin
            seen[i] = subkey;
            step();
         end
         next = 1'b0;
         tests++; if (done !== 1'b1) begin fails++; $display("FAIL rnd_enc_done k%0d got %b want 1", n, done); end
         encrypt = 1'b0; load = 1'b1;
         for (int i = 0; i < 16; i++) exp_q.push_back(seen[15-i]);
         step();
         load = 1'b0; next = 1'b1;
         for (int i = 0; i < 16; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            tests++; if (subkey !== e || subkey_valid !== 1'b1) begin
               fails++; $display("FAIL rnd_reverse k%0d r%0d got %h valid=%b want %h", n, i, subkey, subkey_valid, e);
            end
            step();
         end
         next = 1'b0;
         step();
      end
   endtask

   task automatic test_error();
      logic [47:0] e;
      rst = 1'b1; step(); rst = 1'b0; step();
      next = 1'b1;
      step();
      next = 1'b0;
      tests++; if (error !== 1'b1 || subkey_valid !== 1'b0) begin fails++; $display("FAIL idle_error got error=%b valid=%b want 1/0", error, subkey_valid); end
      step();
      tests++; if (error !== 1'b0 || subkey_valid !== 1'b0) begin fails++; $display("FAIL idle_error_clear got error=%b valid=%b want 0/0", error, subkey_valid); end
      key = KEY0; encrypt = 1'b1; load = 1'b1; next = 1'b1;
      exp_q.push_back(KTAB[0]);
      step();
      load = 1'b0; next = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      tests++; if (round !== 4'd0 || error !== 1'b0 || subkey_valid !== 1'b1) begin
         fails++; $display("FAIL load_next_prio got round=%0d error=%b valid=%b want 0/0/1", round, error, subkey_valid);
      end
      tests++; if (subkey !== e) begin fails++; $display("FAIL load_next_subkey got %h want %h", subkey, e); end
      next = 1'b1;
      exp_q.push_back(KTAB[1]);
      step();
      next = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      tests++; if (round !== 4'd1 || subkey !== e) begin fails++; $display("FAIL first_advance got round=%0d %h want 1 %h", round, subkey, e); end
   endtask

   task automatic test_stall();
      key = KEY0; encrypt = 1'b1; load = 1'b1;
      step();
      load = 1'b0; next = 1'b1;
      for (int i = 0; i < 7; i++) step();
      next = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests++; if (round !== 4'd7 || subkey !== KTAB[7]) begin
            fails++; $display("FAIL stall c%0d got round=%0d %h want 7 %h", i, round, subkey, KTAB[7]);
         end
         step();
      end
      next = 1'b1;
      step(); step();
      next = 1'b0;
      tests++; if (round !== 4'd9 || subkey !== KTAB[9]) begin fails++; $display("FAIL resume got round=%0d %h want 9 %h", round, subkey, KTAB[9]); end
      load = 1'b1;
      step();
      load = 1'b0;
      tests++; if (round !== 4'd0 || done !== 1'b0 || subkey !== KTAB[0] || subkey_valid !== 1'b1) begin
         fails++; $display("FAIL abort_reload got round=%0d done=%b %h want 0/0 %h", round, done, subkey, KTAB[0]);
      end
      step();
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_no_done got %b want 0", done); end
   endtask

   task automatic test_async_reset();
      key = KEY0; encrypt = 1'b1; load = 1'b1;
      step();
      load = 1'b0; next = 1'b1;
      for (int i = 0; i < 4; i++) step();
      next = 1'b0;
      tests++; if (round !== 4'd4 || subkey !== KTAB[4]) begin fails++; $display("FAIL pre_reset got round=%0d %h want 4 %h", round, subkey, KTAB[4]); end
      #2 rst = 1'b1;
      #1;
      tests++; if (subkey_valid !== 1'b0 || round !== 4'd0 || done !== 1'b0 || error !== 1'b0) begin
         fails++; $display("FAIL async_reset got valid=%b round=%0d done=%b error=%b want 0/0/0/0", subkey_valid, round, done, error);
      end
      tests++; if (dut.c_reg !== 28'd0 || dut.d_reg !== 28'd0) begin fails++; $display("FAIL async_reset_cd got %h/%h want 0/0", dut.c_reg, dut.d_reg); end
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++; if (subkey_valid !== 1'b0 || round !== 4'd0 || done !== 1'b0) begin
            fails++; $display("FAIL post_reset_idle c%0d got valid=%b round=%0d done=%b want 0/0/0", i, subkey_valid, round, done);
         end
      end
      load = 1'b1;
      step();
      load = 1'b0;
      tests++; if (subkey_valid !== 1'b1 || subkey !== KTAB[0]) begin fails++; $display("FAIL reload_after_reset got valid=%b %h want 1 %h", subkey_valid, subkey, KTAB[0]); end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_reverse_random();
      test_error();
      test_stall();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
